// File: rtl/wasm_const_decoder.sv
// Streaming decoder for WebAssembly i32/i64/f32/f64.const instructions.
// Integer immediates are signed LEB128; float immediates are raw little-endian bytes.
module wasm_const_decoder #(
  parameter int VW           = 64,
  parameter bit ENABLE_FLOAT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_value,
  output logic [1:0]    out_type,
  output logic [3:0]    out_trap,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid is held with stable payload until ready, and ready never depends on valid.
  typedef enum logic [1:0] {S_IDLE, S_LEB, S_RAW, S_OUT} state_t;

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F32 = 2'd2;
  localparam logic [1:0] T_F64 = 2'd3;

  state_t      state_q, state_d;
  logic [69:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic [63:0] value_q, value_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  trap_q, trap_d;

  logic        accept;
  logic [6:0]  leb_lsb;
  logic [69:0] leb_acc;
  logic        leb_sign;
  logic [63:0] leb_ext;
  logic        leb_last;
  logic        leb_bad;
  logic [63:0] raw_acc;
  logic        raw_last;

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign out_value = value_q[VW-1:0];
  assign out_type  = type_q;
  assign out_trap  = trap_q;
  assign dbg_state = state_q;
  assign accept    = in_valid & in_ready;

  // Byte k of a LEB immediate lands at bit 7k; its sign bit is 7k+6.
  assign leb_lsb  = {cnt_q, 3'b000} - {3'b000, cnt_q};
  assign leb_acc  = acc_q | ({63'b0, in_byte[6:0]} << leb_lsb);
  assign leb_sign = leb_acc[leb_lsb + 7'd6];
  assign leb_ext  = leb_sign ? (leb_acc[63:0] | ({64{1'b1}} << (leb_lsb + 7'd7)))
                             : leb_acc[63:0];
  assign leb_last = kind_q[0] ? (cnt_q == 4'd9) : (cnt_q == 4'd4);
  // On the final byte, the bits that overflow the type width must repeat its sign bit.
  assign leb_bad  = in_byte[7] |
                    (kind_q[0] ? (leb_acc[69:64] != {6{leb_acc[63]}})
                               : (leb_acc[34:32] != {3{leb_acc[31]}}));

  assign raw_acc  = acc_q[63:0] | ({56'b0, in_byte} << {cnt_q, 3'b000});
  assign raw_last = kind_q[0] ? (cnt_q == 4'd7) : (cnt_q == 4'd3);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    value_d = value_q;
    type_d  = type_q;
    trap_d  = trap_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d = '0;
          cnt_d = '0;
          if (in_byte == 8'h41) begin
            kind_d  = T_I32;
            state_d = S_LEB;
          end else if (in_byte == 8'h42 && VW == 64) begin
            kind_d  = T_I64;
            state_d = S_LEB;
          end else if (in_byte == 8'h43 && ENABLE_FLOAT) begin
            kind_d  = T_F32;
            state_d = S_RAW;
          end else if (in_byte == 8'h44 && ENABLE_FLOAT && VW == 64) begin
            kind_d  = T_F64;
            state_d = S_RAW;
          end else begin
            state_d = S_OUT;
            value_d = '0;
            type_d  = '0;
            trap_d  = 4'd1;
          end
        end
      end
      S_LEB: begin
        if (accept) begin
          if (leb_last && leb_bad) begin
            state_d = S_OUT;
            value_d = '0;
            type_d  = '0;
            trap_d  = 4'd2;
          end else if (!leb_last && in_byte[7]) begin
            acc_d = leb_acc;
            cnt_d = cnt_q + 4'd1;
          end else begin
            state_d = S_OUT;
            value_d = kind_q[0] ? leb_ext : {32'b0, leb_ext[31:0]};
            type_d  = kind_q;
            trap_d  = 4'd0;
          end
        end
      end
      S_RAW: begin
        if (accept) begin
          acc_d = {6'b0, raw_acc};
          cnt_d = cnt_q + 4'd1;
          if (raw_last) begin
            state_d = S_OUT;
            value_d = raw_acc;
            type_d  = kind_q;
            trap_d  = 4'd0;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= '0;
      value_q <= '0;
      type_q  <= '0;
      trap_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      value_q <= value_d;
      type_q  <= type_d;
      trap_q  <= trap_d;
    end
  end

endmodule
